// File: rtl/fb_write_ctrl.sv
// Write stage for the 64x32 monochrome framebuffer RAM: word write, single-bit set/clear (read-modify-write), full fill.
// Optional macro FBW_VBLANK_SYNC_EN holds each accepted command until vblank before its first RAM access.
module fb_write_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [$clog2(DATA_W)-1:0] cmd_bit,
   input  logic [DATA_W-1:0]         cmd_data,
   input  logic                      vblank,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         rd_addr,
   input  logic [DATA_W-1:0]         rd_q
);
   localparam int CNT_W = ADDR_W + 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** ADDR_W) - 1);
   localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(RD_LAT - 1);
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_SET   = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_WAIT_VB, S_FILL, S_RD, S_RD_WAIT, S_WR} state_t;

   state_t              r_state;
   logic                r_ready;
   logic                r_busy;
   logic                r_done;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [1:0]          r_op;
   logic [ADDR_W-1:0]   r_addr;
   logic [BIT_W-1:0]    r_bit;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_launch;
   logic                w_capture;
   logic [1:0]          w_op;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W-1:0]   w_mask;
   logic [DATA_W-1:0]   w_mod;
   logic [CNT_W-1:0]    w_cnt_next;

`ifdef FBW_VBLANK_SYNC_EN
   logic [DATA_W-1:0]   r_data;

   // The first RAM access is launched from WAIT_VB using the fields latched at accept.
   assign w_launch = (r_state == S_WAIT_VB) && vblank;
   assign w_op     = r_op;
   assign w_addr   = r_addr;
   assign w_data   = r_data;
`else
   logic                w_unused_vblank;

   assign w_launch = (r_state == S_IDLE) && cmd_valid;
   assign w_op     = cmd_op;
   assign w_addr   = cmd_addr;
   assign w_data   = cmd_data;
   assign w_unused_vblank = vblank;
`endif

   assign w_mask     = DATA_W'(1) << r_bit;
   assign w_mod      = (r_op == OP_SET) ? (rd_q | w_mask) : (rd_q & ~w_mask);
   assign w_cnt_next = r_cnt + CNT_W'(1);
   assign w_capture  = ((r_state == S_RD) && (RD_LAT == 1)) ||
                       ((r_state == S_RD_WAIT) && (r_cnt == WAIT_END));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_rd_addr <= '0;
         r_op      <= OP_WRITE;
         r_addr    <= '0;
         r_bit     <= '0;
         r_cnt     <= '0;
`ifdef FBW_VBLANK_SYNC_EN
         r_data    <= '0;
`endif
      end else begin
         r_done  <= 1'b0;
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op    <= cmd_op;
                  r_addr  <= cmd_addr;
                  r_bit   <= cmd_bit;
`ifdef FBW_VBLANK_SYNC_EN
                  r_data  <= cmd_data;
`endif
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  // Without vblank sync the launch below replaces this state on the same edge.
                  r_state <= S_WAIT_VB;
               end
            end
            S_WAIT_VB: ;
            S_FILL: begin
               if (r_cnt == LAST_CNT) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt     <= w_cnt_next;
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= w_cnt_next[ADDR_W-1:0];
                  r_done    <= (w_cnt_next == LAST_CNT);
               end
            end
            S_RD: begin
               r_state <= S_RD_WAIT;
               r_cnt   <= CNT_W'(1);
            end
            S_RD_WAIT: r_cnt <= w_cnt_next;
            S_WR: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_launch) begin
            case (w_op)
               OP_WRITE: begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= w_addr;
                  r_wr_data <= w_data;
                  r_done    <= 1'b1;
                  r_state   <= S_WR;
               end
               OP_FILL: begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= '0;
                  r_wr_data <= w_data;
                  r_cnt     <= '0;
                  r_done    <= (LAST_CNT == '0);
                  r_state   <= S_FILL;
               end
               default: begin
                  r_rd_addr <= w_addr;
                  r_state   <= S_RD;
               end
            endcase
         end

         // Read data has arrived: write it back with the one target bit forced.
         if (w_capture) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_mod;
            r_done    <= 1'b1;
            r_state   <= S_WR;
         end
      end
   end

   assign cmd_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: two instances (RD_LAT 1 and 3), each with its own RAM,
// checked cycle by cycle against a word-level framebuffer model.
`timescale 1ns/1ps
module tb_fb_write_ctrl;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int DEPTH = 64;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_SET   = 2'b01;
   localparam logic [1:0] OP_CLR   = 2'b10;
   localparam logic [1:0] OP_FILL  = 2'b11;
`ifdef FBW_VBLANK_SYNC_EN
   localparam int VB_EXTRA = 1;
`else
   localparam int VB_EXTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [5:0]  cmd_addr;
   logic [4:0]  cmd_bit;
   logic [31:0] cmd_data;
   logic        vblank;

   logic        cmd_ready_o [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic        wr_en_o [2];
   logic [5:0]  wr_addr_o [2];
   logic [5:0]  rd_addr_o [2];
   logic [31:0] wr_data_o [2];
   logic [31:0] rdq [2];

   logic [31:0] memA [DEPTH];
   logic [31:0] memB [DEPTH];
   logic [31:0] pipeB [2];
   logic [31:0] refMem [DEPTH];

   int vectors = 0;
   int miscompares = 0;

   fb_write_ctrl #(.ADDR_W(6), .DATA_W(32), .RD_LAT(LAT_A)) u_dut_a (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[0]),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_bit(cmd_bit), .cmd_data(cmd_data),
      .vblank(vblank), .busy(busy_o[0]), .done(done_o[0]), .wr_addr(wr_addr_o[0]),
      .wr_data(wr_data_o[0]), .wr_en(wr_en_o[0]), .rd_addr(rd_addr_o[0]), .rd_q(rdq[0]));

   fb_write_ctrl #(.ADDR_W(6), .DATA_W(32), .RD_LAT(LAT_B)) u_dut_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[1]),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_bit(cmd_bit), .cmd_data(cmd_data),
      .vblank(vblank), .busy(busy_o[1]), .done(done_o[1]), .wr_addr(wr_addr_o[1]),
      .wr_data(wr_data_o[1]), .wr_en(wr_en_o[1]), .rd_addr(rd_addr_o[1]), .rd_q(rdq[1]));

   always #5 clk = ~clk;

   // RAM A answers a read in the same cycle; RAM B adds two register stages.
   always @(posedge clk) begin
      if (wr_en_o[0]) memA[wr_addr_o[0]] <= wr_data_o[0];
   end
   always @(posedge clk) begin
      if (wr_en_o[1]) memB[wr_addr_o[1]] <= wr_data_o[1];
      pipeB[0] <= memB[rd_addr_o[1]];
      pipeB[1] <= pipeB[0];
   end
   assign rdq[0] = memA[rd_addr_o[0]];
   assign rdq[1] = pipeB[1];

   function automatic int latOf(input int d);
      return (d == 0) ? LAT_A : LAT_B;
   endfunction

   function automatic logic [31:0] ramWord(input int d, input int i);
      return (d == 0) ? memA[i] : memB[i];
   endfunction

   function automatic logic [31:0] bitRule(input logic [31:0] w, input logic [1:0] op, input logic [4:0] b);
      logic [31:0] m;
      m = 32'h1 << b;
      return (op == OP_SET) ? (w | m) : (w & ~m);
   endfunction

   task automatic jiggleVblank;
`ifndef FBW_VBLANK_SYNC_EN
      vblank = 1'($urandom);
`endif
   endtask

   task automatic do_command(input logic [1:0] op, input logic [5:0] addr, input logic [4:0] b,
                             input logic [31:0] data, input bit noise);
      int first [2];
      int last [2];
      int maxLast;
      int minLast;
      bit rmw;
      logic expEn;
      logic [5:0] expAddr;
      logic [31:0] expWord;
      rmw = (op == OP_SET) || (op == OP_CLR);
      expWord = rmw ? bitRule(refMem[addr], op, b) : data;
      for (int d = 0; d < 2; d++) begin
         first[d] = 1 + VB_EXTRA + (rmw ? latOf(d) : 0);
         last[d]  = first[d] + ((op == OP_FILL) ? DEPTH - 1 : 0);
      end
      maxLast = (last[0] > last[1]) ? last[0] : last[1];
      minLast = (last[0] < last[1]) ? last[0] : last[1];
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (cmd_ready_o[d] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_before_issue dut%0d: got %b, expected 1", d, cmd_ready_o[d]);
         end
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_bit   = b;
      cmd_data  = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int k = 1; k <= maxLast + 1; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            expEn = (k >= first[d]) && (k <= last[d]);
            vectors++;
            if (wr_en_o[d] !== expEn) begin
               miscompares++;
               $display("[TB] FAIL wr_en dut%0d op=%0d k=%0d: got %b, expected %b", d, op, k, wr_en_o[d], expEn);
            end
            vectors++;
            if (done_o[d] !== (k == last[d])) begin
               miscompares++;
               $display("[TB] FAIL done dut%0d op=%0d k=%0d: got %b, expected %b", d, op, k, done_o[d], k == last[d]);
            end
            vectors++;
            if (cmd_ready_o[d] !== (k > last[d]) || busy_o[d] !== (k <= last[d])) begin
               miscompares++;
               $display("[TB] FAIL ready_busy dut%0d op=%0d k=%0d: got ready=%b busy=%b, expected ready=%b",
                        d, op, k, cmd_ready_o[d], busy_o[d], k > last[d]);
            end
            if (expEn) begin
               expAddr = (op == OP_FILL) ? 6'(k - first[d]) : addr;
               vectors++;
               if (wr_addr_o[d] !== expAddr || wr_data_o[d] !== expWord) begin
                  miscompares++;
                  $display("[TB] FAIL write dut%0d op=%0d k=%0d: got %0d/%h, expected %0d/%h",
                           d, op, k, wr_addr_o[d], wr_data_o[d], expAddr, expWord);
               end
            end
            if (rmw && k > VB_EXTRA && k < first[d]) begin
               vectors++;
               if (rd_addr_o[d] !== addr) begin
                  miscompares++;
                  $display("[TB] FAIL rd_addr dut%0d k=%0d: got %0d, expected %0d", d, k, rd_addr_o[d], addr);
               end
            end
         end
         if (noise && k <= minLast) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_addr  = 6'($urandom);
            cmd_bit   = 5'($urandom);
            cmd_data  = $urandom;
         end else begin
            cmd_valid = 1'b0;
         end
         jiggleVblank();
      end
      if (op == OP_FILL) begin
         for (int i = 0; i < DEPTH; i++) refMem[i] = data;
      end else begin
         refMem[addr] = expWord;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      cmd_valid = 1'b1;
      cmd_op = OP_WRITE;
      cmd_addr = 6'd7;
      cmd_data = $urandom;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (cmd_ready_o[d] !== 1'b1 || busy_o[d] !== 1'b0 || wr_en_o[d] !== 1'b0 || done_o[d] !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL reset_ctrl dut%0d cycle %0d: got ready=%b busy=%b wr_en=%b done=%b, expected 1 0 0 0",
                        d, c, cmd_ready_o[d], busy_o[d], wr_en_o[d], done_o[d]);
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (wr_addr_o[d] !== 6'd0 || wr_data_o[d] !== 32'd0 || rd_addr_o[d] !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus dut%0d: got wr_addr=%0d wr_data=%h rd_addr=%0d, expected zeros",
                     d, wr_addr_o[d], wr_data_o[d], rd_addr_o[d]);
         end
      end
      cmd_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_write;
      do_command(OP_WRITE, 6'd5, 5'd0, 32'hA5A5_0F0F, 1'b0);
   endtask

   task automatic test_fill;
      do_command(OP_FILL, 6'($urandom), 5'($urandom), 32'hFFFF_FFFF, 1'b1);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (ramWord(d, i) !== 32'hFFFF_FFFF) begin
               miscompares++;
               $display("[TB] FAIL fill_ram dut%0d addr %0d: got %h, expected ffffffff", d, i, ramWord(d, i));
            end
         end
      end
   endtask

   task automatic test_rmw;
      do_command(OP_WRITE, 6'd9, 5'd0, 32'h0000_00F0, 1'b0);
      do_command(OP_SET, 6'd9, 5'd31, $urandom, 1'b1);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (ramWord(d, 9) !== 32'h8000_00F0) begin
            miscompares++;
            $display("[TB] FAIL set_bit31 dut%0d: got %h, expected 800000f0", d, ramWord(d, 9));
         end
      end
      do_command(OP_CLR, 6'd9, 5'd4, $urandom, 1'b1);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (ramWord(d, 9) !== 32'h8000_00E0) begin
            miscompares++;
            $display("[TB] FAIL clr_bit4 dut%0d: got %h, expected 800000e0", d, ramWord(d, 9));
         end
      end
      do_command(OP_SET, 6'd9, 5'd31, $urandom, 1'b0);
      do_command(OP_CLR, 6'd9, 5'd0, $urandom, 1'b0);
   endtask

   task automatic test_random;
      logic [1:0] op;
      for (int n = 0; n < 40; n++) begin
         op = ($urandom_range(0, 9) == 0) ? OP_FILL : 2'($urandom_range(0, 2));
         do_command(op, 6'($urandom), 5'($urandom), $urandom, 1'b1);
      end
   endtask

   task automatic test_fill_reset;
      logic [31:0] fillData;
      bit found;
      fillData = $urandom;
      cmd_valid = 1'b1;
      cmd_op = OP_FILL;
      cmd_data = fillData;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      found = 1'b0;
      for (int c = 1; c <= 100 && !found; c++) begin
         @(negedge clk);
         if (wr_en_o[0] === 1'b1 && wr_addr_o[0] === 6'd20) begin
            found = 1'b1;
         end else if (c == 4) begin
            cmd_valid = 1'b1;
            cmd_op = OP_WRITE;
            cmd_addr = 6'd40;
            cmd_data = ~fillData;
         end else if (c == 8) begin
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      vectors++;
      if (!found || wr_en_o[1] !== 1'b1 || wr_addr_o[1] !== 6'd20) begin
         miscompares++;
         $display("[TB] FAIL fill_reach_20: got found=%b dutB wr_en=%b addr=%0d, expected 1 1 20",
                  found, wr_en_o[1], wr_addr_o[1]);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (wr_en_o[d] !== 1'b0 || done_o[d] !== 1'b0 || cmd_ready_o[d] !== 1'b1 || busy_o[d] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_abort dut%0d: got wr_en=%b done=%b ready=%b busy=%b, expected 0 0 1 0",
                     d, wr_en_o[d], done_o[d], cmd_ready_o[d], busy_o[d]);
         end
      end
      rst = 1'b1;
      for (int i = 0; i <= 20; i++) refMem[i] = fillData;
   endtask

`ifdef FBW_VBLANK_SYNC_EN
   task automatic test_vblank;
      logic [5:0] a;
      logic [31:0] dat;
      a = 6'($urandom);
      dat = $urandom;
      vblank = 1'b0;
      cmd_valid = 1'b1;
      cmd_op = OP_WRITE;
      cmd_addr = a;
      cmd_data = dat;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (wr_en_o[d] !== 1'b0 || busy_o[d] !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL vb_hold dut%0d c=%0d: got wr_en=%b busy=%b, expected 0 1", d, c, wr_en_o[d], busy_o[d]);
            end
         end
      end
      vblank = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (wr_en_o[d] !== 1'b1 || done_o[d] !== 1'b1 || wr_addr_o[d] !== a || wr_data_o[d] !== dat) begin
            miscompares++;
            $display("[TB] FAIL vb_write dut%0d: got en=%b done=%b %0d/%h, expected 1 1 %0d/%h",
                     d, wr_en_o[d], done_o[d], wr_addr_o[d], wr_data_o[d], a, dat);
         end
      end
      vblank = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (wr_en_o[d] !== 1'b0 || cmd_ready_o[d] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL vb_finish dut%0d: got wr_en=%b ready=%b, expected 0 1", d, wr_en_o[d], cmd_ready_o[d]);
         end
      end
      vblank = 1'b1;
      refMem[a] = dat;
   endtask
`endif

   task automatic test_final_mem;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (ramWord(d, i) !== refMem[i]) begin
               miscompares++;
               $display("[TB] FAIL final_ram dut%0d addr %0d: got %h, expected %h", d, i, ramWord(d, i), refMem[i]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = OP_WRITE;
      cmd_addr = '0;
      cmd_bit = '0;
      cmd_data = '0;
      vblank = 1'b1;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
      test_reset();
      test_write();
      test_fill();
      test_rmw();
      test_random();
      test_fill_reset();
`ifdef FBW_VBLANK_SYNC_EN
      test_vblank();
`endif
      test_final_mem();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
